// File: rtl/msrv32_ahb_dmem_bridge.sv
// ---------------------------------------------------------------------------
// msrv32_ahb_dmem_bridge
//
// Purpose: AHB-Lite master bridge sitting behind the core data-memory port.
// Turns core load/store requests into single-beat AHB-Lite transfers. The
// address phase is issued combinationally in the same cycle as the core
// request. Write data is registered into the following data phase. Illegal
// write masks get a locally generated two-cycle ERROR response. A saturating
// error counter is exported.
//
// Ports:
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_in : clock, async active-low reset
//   core_addr_in, core_wdata_in                 : core address / lane-positioned write data
//   core_wr_req_in, core_wr_mask_in             : write flag and byte-lane mask
//   core_htrans_in                              : 2'b10 = request, anything else idle
//   core_rdata_out, core_hready_out,
//   core_hresp_out                              : response back to the core
//   haddr_out ... hwdata_out                    : AHB-Lite master address/data phase
//   hrdata_in, hready_in, hresp_in              : AHB-Lite slave response
//   err_cnt_out                                 : saturating count of error responses
// ---------------------------------------------------------------------------
module msrv32_ahb_dmem_bridge #(
  parameter int         ERR_CNT_W = 8,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic                 ms_riscv32_mp_clk_in,
  input  logic                 ms_riscv32_mp_rst_in,
  input  logic [31:0]          core_addr_in,
  input  logic [31:0]          core_wdata_in,
  input  logic                 core_wr_req_in,
  input  logic [3:0]           core_wr_mask_in,
  input  logic [1:0]           core_htrans_in,
  output logic [31:0]          core_rdata_out,
  output logic                 core_hready_out,
  output logic                 core_hresp_out,
  output logic [31:0]          haddr_out,
  output logic [1:0]           htrans_out,
  output logic                 hwrite_out,
  output logic [2:0]           hsize_out,
  output logic [2:0]           hburst_out,
  output logic [3:0]           hprot_out,
  output logic [31:0]          hwdata_out,
  input  logic [31:0]          hrdata_in,
  input  logic                 hready_in,
  input  logic                 hresp_in,
  output logic [ERR_CNT_W-1:0] err_cnt_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t                 state_q, state_d;
  logic [31:0]            hwdata_q;
  logic [ERR_CNT_W-1:0]   err_cnt_q;

  logic                   req;
  logic                   mask_ok;
  logic [1:0]             lane_lo;
  logic [2:0]             lane_size;
  logic                   legal;
  logic                   slot_open;
  logic                   issue;
  logic                   accept;
  logic                   err_inc;
  logic                   unused_addr_bits;

  // Reads are always word aligned, so the core's low address bits are unused.
  assign unused_addr_bits = ^core_addr_in[1:0];

  // Byte-mask decode: gives the AHB low address bits and HSIZE for writes.
  always_comb begin
    mask_ok   = 1'b1;
    lane_lo   = 2'b00;
    lane_size = 3'b010;
    case (core_wr_mask_in)
      4'b0001: begin lane_lo = 2'b00; lane_size = 3'b000; end
      4'b0010: begin lane_lo = 2'b01; lane_size = 3'b000; end
      4'b0100: begin lane_lo = 2'b10; lane_size = 3'b000; end
      4'b1000: begin lane_lo = 2'b11; lane_size = 3'b000; end
      4'b0011: begin lane_lo = 2'b00; lane_size = 3'b001; end
      4'b1100: begin lane_lo = 2'b10; lane_size = 3'b001; end
      4'b1111: begin lane_lo = 2'b00; lane_size = 3'b010; end
      default: mask_ok = 1'b0;
    endcase
  end

  assign req   = (core_htrans_in == HTRANS_NONSEQ);
  assign legal = !core_wr_req_in || mask_ok;

  // An address phase may be driven in IDLE/ERR2, and in DATA except during the
  // first slave error cycle, where AHB-Lite requires the master to go IDLE.
  // Reset also blocks it so nothing leaks onto the bus while rst_n is low.
  always_comb begin
    slot_open = 1'b0;
    case (state_q)
      ST_IDLE: slot_open = 1'b1;
      ST_DATA: slot_open = !(hresp_in && !hready_in);
      ST_ERR1: slot_open = 1'b0;
      ST_ERR2: slot_open = 1'b1;
      default: slot_open = 1'b0;
    endcase
    issue  = req && legal && slot_open && ms_riscv32_mp_rst_in;
    // The transfer is only taken by the slave once HREADY is high, and a DATA
    // phase ending in error never launches a follow-on transfer.
    accept = issue && hready_in && !((state_q == ST_DATA) && hresp_in);
  end

  // Next-state logic. Illegal requests divert into the local error sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept)            state_d = ST_DATA;
        else if (req && !legal) state_d = ST_ERR1;
      end
      ST_DATA: begin
        if (hready_in) begin
          if (accept)             state_d = ST_DATA;
          else if (req && !legal) state_d = ST_ERR1;
          else                    state_d = ST_IDLE;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: begin
        if (accept)             state_d = ST_DATA;
        else if (req && !legal) state_d = ST_ERR1;
        else                    state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Core-side response: slave response passes through only while a bus data
  // phase is outstanding; the ERR states fake the two-cycle AHB error.
  always_comb begin
    core_hready_out = 1'b1;
    core_hresp_out  = 1'b0;
    case (state_q)
      ST_IDLE: begin core_hready_out = 1'b1;      core_hresp_out = 1'b0;     end
      ST_DATA: begin core_hready_out = hready_in; core_hresp_out = hresp_in; end
      ST_ERR1: begin core_hready_out = 1'b0;      core_hresp_out = 1'b1;     end
      ST_ERR2: begin core_hready_out = 1'b1;      core_hresp_out = 1'b1;     end
      default: begin core_hready_out = 1'b1;      core_hresp_out = 1'b0;     end
    endcase
  end

  assign htrans_out     = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr_out      = {core_addr_in[31:2], (core_wr_req_in ? lane_lo : 2'b00)};
  assign hsize_out      = core_wr_req_in ? lane_size : 3'b010;
  assign hwrite_out     = core_wr_req_in;
  assign hburst_out     = 3'b000;
  assign hprot_out      = HPROT_VAL;
  assign hwdata_out     = hwdata_q;
  assign core_rdata_out = hrdata_in;
  assign err_cnt_out    = err_cnt_q;

  // Count slave errors on their final cycle, and local errors on ERR1->ERR2.
  assign err_inc = ((state_q == ST_DATA) && hready_in && hresp_in) || (state_q == ST_ERR1);

  // State, write-data and error-counter registers.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_q   <= ST_IDLE;
      hwdata_q  <= 32'h0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept && core_wr_req_in)
        hwdata_q <= core_wdata_in;
      if (err_inc && (err_cnt_q != {ERR_CNT_W{1'b1}}))
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_msrv32_ahb_dmem_bridge.sv
// ---------------------------------------------------------------------------
// tb_msrv32_ahb_dmem_bridge
//
// Purpose: self-checking bench for msrv32_ahb_dmem_bridge. Inputs are driven
// on the falling clock edge and outputs sampled 1 ns later. Expected values
// come from a transaction-level view of the bridge: lane/size derived from the
// mask by bit counting, a saturating error total, and the last written data.
// ---------------------------------------------------------------------------
module tb_msrv32_ahb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] core_addr_in, core_wdata_in;
  logic        core_wr_req_in;
  logic [3:0]  core_wr_mask_in;
  logic [1:0]  core_htrans_in;
  logic [31:0] core_rdata_out;
  logic        core_hready_out, core_hresp_out;
  logic [31:0] haddr_out;
  logic [1:0]  htrans_out;
  logic        hwrite_out;
  logic [2:0]  hsize_out, hburst_out;
  logic [3:0]  hprot_out;
  logic [31:0] hwdata_out, hrdata_in;
  logic        hready_in, hresp_in;
  logic [7:0]  err_cnt_out;

  int          vectors = 0;
  int          miscompares = 0;
  int          exp_err = 0;
  logic [31:0] exp_hwdata = 32'h0;

  always #5 clk = ~clk;

  msrv32_ahb_dmem_bridge #(.ERR_CNT_W(8), .HPROT_VAL(4'b0011)) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst_n),
    .core_addr_in(core_addr_in),
    .core_wdata_in(core_wdata_in),
    .core_wr_req_in(core_wr_req_in),
    .core_wr_mask_in(core_wr_mask_in),
    .core_htrans_in(core_htrans_in),
    .core_rdata_out(core_rdata_out),
    .core_hready_out(core_hready_out),
    .core_hresp_out(core_hresp_out),
    .haddr_out(haddr_out),
    .htrans_out(htrans_out),
    .hwrite_out(hwrite_out),
    .hsize_out(hsize_out),
    .hburst_out(hburst_out),
    .hprot_out(hprot_out),
    .hwdata_out(hwdata_out),
    .hrdata_in(hrdata_in),
    .hready_in(hready_in),
    .hresp_in(hresp_in),
    .err_cnt_out(err_cnt_out)
  );

  // Reference rule for byte masks: a legal mask is a naturally aligned run of
  // 1, 2 or 4 lanes; its first lane gives the address, its length the size.
  function automatic void lane_info(input logic [3:0] mask, output bit ok,
                                    output logic [1:0] lo, output logic [2:0] sz);
    int pc = 0;
    int l  = -1;
    int run;
    for (int i = 0; i < 4; i++)
      if (mask[i]) begin
        pc++;
        if (l < 0) l = i;
      end
    ok = 1'b0;
    if (pc == 1 || pc == 2 || pc == 4) begin
      run = ((1 << pc) - 1) << l;
      if ((l % pc) == 0 && int'(mask) == run) ok = 1'b1;
    end
    lo = (l < 0) ? 2'd0 : 2'(l);
    sz = (pc == 4) ? 3'd2 : (pc == 2) ? 3'd1 : 3'd0;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  task automatic idle_inputs();
    core_htrans_in  = 2'b00;
    core_wr_req_in  = 1'b0;
    core_wr_mask_in = 4'h0;
    core_addr_in    = 32'h0;
    core_wdata_in   = 32'h0;
    hready_in       = 1'b1;
    hresp_in        = 1'b0;
    hrdata_in       = 32'h0;
  endtask

  task automatic present(input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask);
    core_htrans_in  = 2'b10;
    core_wr_req_in  = wr;
    core_addr_in    = addr;
    core_wdata_in   = wdata;
    core_wr_mask_in = mask;
  endtask

  // Reset values, including a request presented while reset is held.
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    present(1'b0, 32'h0000_4000, 32'h0, 4'h0);
    @(negedge clk); #1;
    vectors++; if (htrans_out !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_htrans got %h exp 0", htrans_out); end
    vectors++; if (core_hready_out !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_hready got %b exp 1", core_hready_out); end
    vectors++; if (core_hresp_out !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_hresp got %b exp 0", core_hresp_out); end
    vectors++; if (err_cnt_out !== 8'd0) begin miscompares++; $display("[TB] FAIL rst_errcnt got %0d exp 0", err_cnt_out); end
    vectors++; if (hwdata_out !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_hwdata got %h exp 0", hwdata_out); end
    vectors++; if (hburst_out !== 3'b000) begin miscompares++; $display("[TB] FAIL hburst got %b exp 000", hburst_out); end
    vectors++; if (hprot_out !== 4'b0011) begin miscompares++; $display("[TB] FAIL hprot got %b exp 0011", hprot_out); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    exp_err = 0;
    exp_hwdata = 32'h0;
  endtask

  // Word read, then a byte write followed immediately by a read.
  task automatic test_directed();
    @(negedge clk); idle_inputs(); present(1'b0, 32'h0000_1004, 32'h0, 4'h0); #1;
    vectors++; if (htrans_out !== 2'b10) begin miscompares++; $display("[TB] FAIL rd_htrans got %h exp 2", htrans_out); end
    vectors++; if (haddr_out !== 32'h0000_1004) begin miscompares++; $display("[TB] FAIL rd_haddr got %h exp 00001004", haddr_out); end
    vectors++; if (hsize_out !== 3'b010) begin miscompares++; $display("[TB] FAIL rd_hsize got %b exp 010", hsize_out); end
    @(negedge clk); idle_inputs(); hrdata_in = 32'hDEAD_BEEF; #1;
    vectors++; if (core_rdata_out !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL rd_rdata got %h exp deadbeef", core_rdata_out); end
    vectors++; if (core_hready_out !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_hready got %b exp 1", core_hready_out); end

    @(negedge clk); idle_inputs(); present(1'b1, 32'h0000_2000, 32'h00AB_0000, 4'b0100); #1;
    vectors++; if (haddr_out !== 32'h0000_2002) begin miscompares++; $display("[TB] FAIL wr_haddr got %h exp 00002002", haddr_out); end
    vectors++; if (hsize_out !== 3'b000) begin miscompares++; $display("[TB] FAIL wr_hsize got %b exp 000", hsize_out); end
    vectors++; if (hwrite_out !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_hwrite got %b exp 1", hwrite_out); end
    vectors++; if (htrans_out !== 2'b10) begin miscompares++; $display("[TB] FAIL wr_htrans got %h exp 2", htrans_out); end
    exp_hwdata = 32'h00AB_0000;
    @(negedge clk); idle_inputs(); present(1'b0, 32'h0000_3008, 32'h0, 4'h0); #1;
    vectors++; if (hwdata_out !== exp_hwdata) begin miscompares++; $display("[TB] FAIL b2b_hwdata got %h exp %h", hwdata_out, exp_hwdata); end
    vectors++; if (htrans_out !== 2'b10) begin miscompares++; $display("[TB] FAIL b2b_htrans got %h exp 2", htrans_out); end
    vectors++; if (haddr_out !== 32'h0000_3008) begin miscompares++; $display("[TB] FAIL b2b_haddr got %h exp 00003008", haddr_out); end
    vectors++; if (hwrite_out !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_hwrite got %b exp 0", hwrite_out); end
    @(negedge clk); idle_inputs(); hrdata_in = 32'h1234_5678; #1;
    vectors++; if (core_rdata_out !== 32'h1234_5678) begin miscompares++; $display("[TB] FAIL b2b_rdata got %h exp 12345678", core_rdata_out); end
    vectors++; if (hwdata_out !== exp_hwdata) begin miscompares++; $display("[TB] FAIL hwdata_hold got %h exp %h", hwdata_out, exp_hwdata); end
  endtask

  // Three slave wait states, completion on the fourth data cycle.
  task automatic test_wait_states();
    logic [31:0] rd;
    @(negedge clk); idle_inputs(); present(1'b0, 32'h0000_5010, 32'h0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); idle_inputs(); hready_in = 1'b0; #1;
      vectors++; if (core_hready_out !== 1'b0) begin miscompares++; $display("[TB] FAIL wait_hready[%0d] got %b exp 0", k, core_hready_out); end
    end
    rd = $urandom;
    @(negedge clk); idle_inputs(); hrdata_in = rd; #1;
    vectors++; if (core_hready_out !== 1'b1) begin miscompares++; $display("[TB] FAIL wait_done got %b exp 1", core_hready_out); end
    vectors++; if (core_rdata_out !== rd) begin miscompares++; $display("[TB] FAIL wait_rdata got %h exp %h", core_rdata_out, rd); end
  endtask

  // Two-cycle slave error with a follow-on request that must not be issued.
  task automatic test_slave_error();
    @(negedge clk); idle_inputs(); present(1'b1, 32'h0000_6000, 32'hCAFE_F00D, 4'hF);
    exp_hwdata = 32'hCAFE_F00D;
    @(negedge clk); idle_inputs(); present(1'b0, 32'h0000_7000, 32'h0, 4'h0);
    hready_in = 1'b0; hresp_in = 1'b1; #1;
    vectors++; if (htrans_out !== 2'b00) begin miscompares++; $display("[TB] FAIL serr_htrans got %h exp 0", htrans_out); end
    vectors++; if ({core_hready_out, core_hresp_out} !== 2'b01) begin miscompares++; $display("[TB] FAIL serr_c1 got %b exp 01", {core_hready_out, core_hresp_out}); end
    @(negedge clk); idle_inputs(); hready_in = 1'b1; hresp_in = 1'b1; #1;
    vectors++; if ({core_hready_out, core_hresp_out} !== 2'b11) begin miscompares++; $display("[TB] FAIL serr_c2 got %b exp 11", {core_hready_out, core_hresp_out}); end
    exp_err = sat_inc(exp_err);
    @(negedge clk); idle_inputs(); #1;
    vectors++; if (err_cnt_out !== 8'(exp_err)) begin miscompares++; $display("[TB] FAIL serr_cnt got %0d exp %0d", err_cnt_out, exp_err); end
    vectors++; if ({core_hready_out, core_hresp_out} !== 2'b10) begin miscompares++; $display("[TB] FAIL serr_idle got %b exp 10", {core_hready_out, core_hresp_out}); end
  endtask

  // Illegal write masks repeated until the error counter saturates.
  task automatic test_saturation();
    for (int n = 0; n < 260; n++) begin
      @(negedge clk); idle_inputs(); present(1'b1, 32'h0000_8000, 32'h1, 4'b0101); #1;
      vectors++; if (htrans_out !== 2'b00) begin miscompares++; $display("[TB] FAIL ill_htrans[%0d] got %h exp 0", n, htrans_out); end
      @(negedge clk); #1;
      vectors++; if ({core_hready_out, core_hresp_out, htrans_out} !== 4'b0100) begin miscompares++; $display("[TB] FAIL ill_c1[%0d] got %b exp 0100", n, {core_hready_out, core_hresp_out, htrans_out}); end
      exp_err = sat_inc(exp_err);
      @(negedge clk); idle_inputs(); #1;
      vectors++; if ({core_hready_out, core_hresp_out} !== 2'b11) begin miscompares++; $display("[TB] FAIL ill_c2[%0d] got %b exp 11", n, {core_hready_out, core_hresp_out}); end
      vectors++; if (err_cnt_out !== 8'(exp_err)) begin miscompares++; $display("[TB] FAIL ill_cnt[%0d] got %0d exp %0d", n, err_cnt_out, exp_err); end
    end
    vectors++; if (err_cnt_out !== 8'd255) begin miscompares++; $display("[TB] FAIL sat_cnt got %0d exp 255", err_cnt_out); end
  endtask

  // Random single transfers: random direction, mask, wait states and errors.
  task automatic test_random_single();
    bit ok, wr, err, legal;
    logic [1:0] lo;
    logic [2:0] sz;
    logic [31:0] addr, wdata, rd;
    logic [3:0] mask;
    int waits;
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom); addr = $urandom; wdata = $urandom; mask = 4'($urandom);
      waits = $urandom_range(0, 3); err = ($urandom_range(0, 4) == 0);
      lane_info(mask, ok, lo, sz);
      legal = !wr || ok;
      @(negedge clk); idle_inputs(); present(wr, addr, wdata, mask); #1;
      vectors++; if (err_cnt_out !== 8'(exp_err)) begin miscompares++; $display("[TB] FAIL rnd_cnt[%0d] got %0d exp %0d", t, err_cnt_out, exp_err); end
      vectors++; if (htrans_out !== (legal ? 2'b10 : 2'b00)) begin miscompares++; $display("[TB] FAIL rnd_htrans[%0d] got %h exp %h", t, htrans_out, legal ? 2'b10 : 2'b00); end
      if (legal) begin
        vectors++; if (haddr_out !== {addr[31:2], (wr ? lo : 2'b00)}) begin miscompares++; $display("[TB] FAIL rnd_haddr[%0d] got %h exp %h", t, haddr_out, {addr[31:2], (wr ? lo : 2'b00)}); end
        vectors++; if (hsize_out !== (wr ? sz : 3'd2)) begin miscompares++; $display("[TB] FAIL rnd_hsize[%0d] got %0d exp %0d", t, hsize_out, wr ? sz : 3'd2); end
        if (wr) exp_hwdata = wdata;
        for (int k = 0; k < waits; k++) begin
          @(negedge clk); idle_inputs(); hready_in = 1'b0; #1;
          vectors++; if ({core_hready_out, core_hresp_out} !== 2'b00) begin miscompares++; $display("[TB] FAIL rnd_wait[%0d] got %b exp 00", t, {core_hready_out, core_hresp_out}); end
        end
        if (err) begin
          @(negedge clk); idle_inputs(); hready_in = 1'b0; hresp_in = 1'b1; #1;
          vectors++; if ({core_hready_out, core_hresp_out} !== 2'b01) begin miscompares++; $display("[TB] FAIL rnd_err1[%0d] got %b exp 01", t, {core_hready_out, core_hresp_out}); end
          @(negedge clk); idle_inputs(); hresp_in = 1'b1; #1;
          vectors++; if ({core_hready_out, core_hresp_out} !== 2'b11) begin miscompares++; $display("[TB] FAIL rnd_err2[%0d] got %b exp 11", t, {core_hready_out, core_hresp_out}); end
          exp_err = sat_inc(exp_err);
        end else begin
          rd = $urandom;
          @(negedge clk); idle_inputs(); hrdata_in = rd; #1;
          vectors++; if ({core_hready_out, core_hresp_out} !== 2'b10) begin miscompares++; $display("[TB] FAIL rnd_done[%0d] got %b exp 10", t, {core_hready_out, core_hresp_out}); end
          if (!wr) begin
            vectors++; if (core_rdata_out !== rd) begin miscompares++; $display("[TB] FAIL rnd_rdata[%0d] got %h exp %h", t, core_rdata_out, rd); end
          end
        end
        vectors++; if (hwdata_out !== exp_hwdata) begin miscompares++; $display("[TB] FAIL rnd_hwdata[%0d] got %h exp %h", t, hwdata_out, exp_hwdata); end
      end else begin
        @(negedge clk); #1;
        vectors++; if ({core_hready_out, core_hresp_out} !== 2'b01) begin miscompares++; $display("[TB] FAIL rnd_ill1[%0d] got %b exp 01", t, {core_hready_out, core_hresp_out}); end
        exp_err = sat_inc(exp_err);
        @(negedge clk); idle_inputs(); #1;
        vectors++; if ({core_hready_out, core_hresp_out} !== 2'b11) begin miscompares++; $display("[TB] FAIL rnd_ill2[%0d] got %b exp 11", t, {core_hready_out, core_hresp_out}); end
      end
    end
  endtask

  // Pipelined legal transfers: each next address goes out in the last data
  // cycle of the previous one and is held through its wait states.
  task automatic test_back_to_back();
    logic [3:0] legal_masks [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    bit          t_wr [31];
    logic [31:0] t_addr [31];
    logic [31:0] t_wdata [31];
    logic [3:0]  t_mask [31];
    bit ok;
    logic [1:0] lo;
    logic [2:0] sz;
    logic [31:0] rd;
    int waits;
    for (int i = 0; i < 30; i++) begin
      t_wr[i] = 1'($urandom); t_addr[i] = $urandom; t_wdata[i] = $urandom;
      t_mask[i] = legal_masks[$urandom_range(0, 6)];
    end
    @(negedge clk); idle_inputs(); present(t_wr[0], t_addr[0], t_wdata[0], t_mask[0]); #1;
    lane_info(t_mask[0], ok, lo, sz);
    vectors++; if (htrans_out !== 2'b10) begin miscompares++; $display("[TB] FAIL b2b_first got %h exp 2", htrans_out); end
    for (int i = 1; i <= 30; i++) begin
      if (t_wr[i-1]) exp_hwdata = t_wdata[i-1];
      waits = $urandom_range(0, 2);
      if (i < 30) lane_info(t_mask[i], ok, lo, sz);
      for (int k = 0; k <= waits; k++) begin
        @(negedge clk); idle_inputs();
        if (i < 30) present(t_wr[i], t_addr[i], t_wdata[i], t_mask[i]);
        rd = $urandom; hrdata_in = rd;
        hready_in = (k == waits); #1;
        vectors++; if (core_hready_out !== (k == waits)) begin miscompares++; $display("[TB] FAIL pipe_hready[%0d] got %b exp %b", i, core_hready_out, k == waits); end
        vectors++; if (hwdata_out !== exp_hwdata) begin miscompares++; $display("[TB] FAIL pipe_hwdata[%0d] got %h exp %h", i, hwdata_out, exp_hwdata); end
        if (i < 30) begin
          vectors++; if (htrans_out !== 2'b10) begin miscompares++; $display("[TB] FAIL pipe_htrans[%0d] got %h exp 2", i, htrans_out); end
          vectors++; if (haddr_out !== {t_addr[i][31:2], (t_wr[i] ? lo : 2'b00)}) begin miscompares++; $display("[TB] FAIL pipe_haddr[%0d] got %h", i, haddr_out); end
          vectors++; if (hsize_out !== (t_wr[i] ? sz : 3'd2)) begin miscompares++; $display("[TB] FAIL pipe_hsize[%0d] got %0d exp %0d", i, hsize_out, t_wr[i] ? sz : 3'd2); end
        end
        if (k == waits && !t_wr[i-1]) begin
          vectors++; if (core_rdata_out !== rd) begin miscompares++; $display("[TB] FAIL pipe_rdata[%0d] got %h exp %h", i, core_rdata_out, rd); end
        end
      end
    end
  endtask

  // Asynchronous reset in the middle of a stalled data phase.
  task automatic test_async_reset();
    logic [31:0] rd;
    @(negedge clk); idle_inputs(); present(1'b0, 32'h0000_9000, 32'h0, 4'h0);
    @(negedge clk); idle_inputs(); present(1'b0, 32'h0000_9100, 32'h0, 4'h0); hready_in = 1'b0; #1;
    vectors++; if (core_hready_out !== 1'b0) begin miscompares++; $display("[TB] FAIL ar_stall got %b exp 0", core_hready_out); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (htrans_out !== 2'b00) begin miscompares++; $display("[TB] FAIL ar_htrans got %h exp 0", htrans_out); end
    vectors++; if (core_hready_out !== 1'b1) begin miscompares++; $display("[TB] FAIL ar_hready got %b exp 1", core_hready_out); end
    vectors++; if (err_cnt_out !== 8'd0) begin miscompares++; $display("[TB] FAIL ar_errcnt got %0d exp 0", err_cnt_out); end
    vectors++; if (hwdata_out !== 32'h0) begin miscompares++; $display("[TB] FAIL ar_hwdata got %h exp 0", hwdata_out); end
    exp_err = 0; exp_hwdata = 32'h0;
    @(negedge clk); idle_inputs(); rst_n = 1'b1;
    @(negedge clk); idle_inputs(); present(1'b0, 32'h0000_A00C, 32'h0, 4'h0); #1;
    vectors++; if ({htrans_out, haddr_out} !== {2'b10, 32'h0000_A00C}) begin miscompares++; $display("[TB] FAIL ar_fresh got %h/%h exp 2/0000a00c", htrans_out, haddr_out); end
    rd = $urandom;
    @(negedge clk); idle_inputs(); hrdata_in = rd; #1;
    vectors++; if ({core_hready_out, core_rdata_out} !== {1'b1, rd}) begin miscompares++; $display("[TB] FAIL ar_rdata got %b/%h exp 1/%h", core_hready_out, core_rdata_out, rd); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_directed();
    test_wait_states();
    test_slave_error();
    test_random_single();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/msrv32_ahb_dmem_bridge.md
Name: msrv32_ahb_dmem_bridge

Overview:
- AHB-Lite master bridge downstream of the core data-memory port.
- Core side: the core drives dmaddr/dmdata/dmwr_req/dmwr_mask/data_htrans and consumes data_in/data_hready/hresp.
- Bridge converts these into legal single-beat AHB-Lite transfers. It registers write data into the data phase, derives HSIZE and low address bits from the byte mask, and generates a local two-cycle ERROR response for illegal write masks.
- A saturating bus-error counter is exported as status.

Parameters:
ERR_CNT_W, 8, width of saturating error counter
HPROT_VAL, 4'b0011, constant HPROT (data, privileged)

Ports:
ms_riscv32_mp_clk_in  in  1  clock
ms_riscv32_mp_rst_in  in  1  reset, asynchronous, active-low
core_addr_in  in  32  core data address (dmaddr)
core_wdata_in  in  32  lane-positioned write data (dmdata)
core_wr_req_in  in  1  1=write, 0=read
core_wr_mask_in  in  4  byte-lane mask (writes)
core_htrans_in  in  2  2'b10=request, 2'b00=idle; other codes treated as idle
core_rdata_out  out  32  read data to load unit
core_hready_out  out  1  ready to core
core_hresp_out  out  1  error to core
haddr_out  out  32  AHB HADDR
htrans_out  out  2  AHB HTRANS (IDLE/NONSEQ only)
hwrite_out  out  1  AHB HWRITE
hsize_out  out  3  AHB HSIZE
hburst_out  out  3  constant 3'b000 (SINGLE)
hprot_out  out  4  constant HPROT_VAL
hwdata_out  out  32  AHB HWDATA
hrdata_in  in  32  AHB HRDATA
hready_in  in  1  AHB HREADY
hresp_in  in  1  AHB HRESP
err_cnt_out  out  ERR_CNT_W  saturating count of error responses

Behaviour:
- States: IDLE (no data phase outstanding), DATA (bus data phase outstanding), ERR1, ERR2 (local error cycles).
- Reset (async, rst low): state=IDLE, hwdata register=0, write flag=0, err_cnt=0. During reset: htrans_out=IDLE, core_hready_out=1, core_hresp_out=0.
- Request: core_htrans_in==2'b10.
- Legal write masks: 0001, 0010, 0100, 1000, 0011, 1100, 1111. Mask 0000 and all other masks are illegal. Reads are always legal.
- Accept: request && legal && hready_in && state in {IDLE, DATA, ERR2}. DATA is included only on the cycle when hready_in=1 and hresp_in=0.
- Address phase is combinational from core inputs:
  - htrans_out=NONSEQ iff accept-qualifying request (legal, state allows), else IDLE.
  - Forced IDLE in ERR1, and in DATA while hresp_in=1 && hready_in=0 (first slave error cycle).
- Reads: haddr_out={core_addr_in[31:2],2'b00}; hsize_out=3'b010.
- Writes: haddr_out[31:2]=core_addr_in[31:2]. haddr_out[1:0] and hsize_out come from the mask:
  - 0001→00/byte, 0010→01/byte, 0100→10/byte, 1000→11/byte
  - 0011→00/half, 1100→10/half
  - 1111→00/word
- hwrite_out=core_wr_req_in.
- On accept: register core_wdata_in. hwdata_out is driven from this register during the following data phase and is held until the next accepted write.
- Core holds all request inputs stable while core_hready_out=0. The bridge relies on this for AHB address hold.
- Transitions:
  - IDLE: accept→DATA; request with illegal mask→ERR1; else stay.
  - DATA: hready_in=0→stay. hready_in=1: accept→DATA; illegal request→ERR1; else→IDLE.
  - ERR1→ERR2 unconditionally.
  - ERR2: accept→DATA; illegal→ERR1; else→IDLE.
- Core response:
  - IDLE: hready=1, hresp=0.
  - DATA: hready=hready_in, hresp=hresp_in.
  - ERR1: hready=0, hresp=1.
  - ERR2: hready=1, hresp=1.
  - core_rdata_out=hrdata_in always; valid only when DATA && hready_in && !hresp_in.
- err_cnt increments by 1 on (DATA && hready_in && hresp_in) or on entering ERR2. It saturates at all-ones and never wraps.
- Latency: zero added cycles. Address is issued in the same cycle as the core request; data returns per slave wait states.
- Back-to-back transfers pipeline with no bubble.

Test Plan:
- Word read 0x0000_1004, zero wait → htrans NONSEQ, haddr 0x1004, hsize 010. Next cycle hrdata 0xDEADBEEF → core_rdata 0xDEADBEEF, core_hready 1.
- Byte write addr 0x2000, mask 0100, wdata 0x00AB0000 → haddr 0x2002, hsize 000, hwrite 1. Next cycle hwdata 0x00AB0000. A back-to-back read issues in that same cycle.
- Slave inserts 3 wait states (hready_in 0) → core_hready 0 for 3 cycles, state stays DATA; completion on 4th cycle.
- Slave ERROR (hready 0/hresp 1, then 1/1) → htrans_out IDLE in first cycle; core sees 0/1 then 1/1; err_cnt 0→1.
- Illegal mask 0101 write → no NONSEQ issued; core sees 0/1 then 1/1; err_cnt increments. Repeated 260 times with ERR_CNT_W=8 → err_cnt saturates at 255.
- Assert reset during DATA with hready_in 0 → htrans IDLE, core_hready 1, err_cnt 0 immediately (async). After release, a fresh read is issued correctly.
